serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder with carry-in: captures two operands on a start pulse, adds them LSB-first through a single one-bit full-adder cell and a carry flip-flop, and presents the sum and carry-out after WIDTH cycles. It is the addition counterpart of the team's one-bit subtractor cell. It serves as the area-minimal arithmetic unit for slow datapaths in the Adder_Subtractor library.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  augend; captured on accepted start
- b  input  WIDTH  addend; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result; held until the next accepted start
- cout  output  1  final carry; held with sum

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, load a/b into shift registers, load the carry flop with cin, clear the bit counter, and go to RUN. With start=0, remain in IDLE.
- RUN: each cycle, feed the LSBs of the a and b shift registers plus the carry flop into the full-adder cell.
  - Shift the sum bit into the sum register MSB-side, so the result right-aligns after WIDTH shifts.
  - Shift the a and b registers right by one.
  - Update the carry flop from the cell's carry output.
  - Increment the counter. When counter = WIDTH-1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. sum holds (a+b+cin) mod 2^WIDTH and cout holds bit WIDTH of the full sum.
- start while busy=1 is ignored; there is no queueing. start in the DONE cycle is also ignored.
- sum and cout change only during RUN shifting. After done they stay stable until the next accepted start.
- Counter width is $clog2(WIDTH). It never wraps within an operation.
- Reset values: busy=0, done=0, sum=0, cout=0, FSM=IDLE, counter=0, carry flop=0.
- rst during RUN or DONE aborts the operation. All outputs return to reset values on the next edge and no done is emitted. rst has priority over start in the same cycle.

## Timing
- Start accepted at edge T0. busy=1 from T0+1 through the edge that leaves DONE.
- RUN occupies WIDTH cycles, T0+1 .. T0+WIDTH.
- done=1 in cycle T0+WIDTH+1. Start-to-done latency is WIDTH+1 cycles.
- busy=0 and ready for a new start in cycle T0+WIDTH+2.
- Throughput is one operation per WIDTH+2 cycles.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined: adds output `ovf` (1 bit, reset 0).
  - ovf is the two's-complement signed overflow: the XOR of the carry into and out of the MSB position, captured on the final RUN cycle.
  - ovf is valid with done and held alongside sum.
- SERIAL_ADDER_OVF_EN undefined: no ovf port and no associated logic. All other behaviour is identical.

## Structure
- Package `serial_adder_pkg` holds the state typedef `serial_adder_state_t` (IDLE, RUN, DONE) and the localparams for the state encoding.
- Sub-module `full_adder` is a one-bit combinational cell: inputs a, b, c; outputs sum, carry, where sum=a^b^c and carry=ab|ac|bc. It is instantiated once.
- Top level contains the FSM, operand shift registers, sum register, carry flop, and counter.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then 5 idle cycles → busy=0, done=0, sum=0, cout=0 throughout.
- Basic add, WIDTH=8: a=8'h35, b=8'h4A, cin=0, start one cycle → done exactly 9 cycles after start, sum=8'h7F, cout=0.
- Carry chain: a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1. With SERIAL_ADDER_OVF_EN defined: a=8'h7F, b=8'h01 → sum=8'h80, ovf=1.
- Start while busy: start at T0 (a=1, b=2), start again at T0+3 (a=8'hF0, b=8'h0F) → single done with sum=8'h03; the second request is dropped.
- Reset mid-operation: start a=8'hAA, b=8'h55; rst at T0+4 → no done pulse, outputs return to 0. A fresh start afterwards yields the correct result.
- Exhaustive, WIDTH=4: all 512 combinations of a, b, cin issued back-to-back at busy=0 → {cout,sum} equals a+b+cin for every combination.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   serial_adder_state_t : FSM state type (IDLE, RUN, DONE)
//   ST_*                 : state encodings
//   cnt_width()          : bit-counter width for a given operand width
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } serial_adder_state_t;

  // Counter must index WIDTH shifts (0..WIDTH-1); keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit combinational full-adder cell.
//   a, b  : operand bits
//   c     : carry in
//   sum   : a ^ b ^ c
//   carry : majority(a, b, c)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with carry-in, LSB first.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, accepted only in IDLE
//   a, b, cin     : operands and carry-in, captured on accepted start
//   busy          : high in RUN and DONE
//   done          : one-cycle pulse when sum/cout (and ovf) are valid
//   sum, cout     : result, held until the next accepted start
//   ovf           : signed overflow, only when SERIAL_ADDER_OVF_EN is defined
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned        CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  serial_adder_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept;
  logic shifting;
  logic last_bit;
  logic fa_sum;
  logic fa_carry;

  // Single shared cell: operand LSBs plus the carry flop.
  full_adder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign accept   = (state_q == IDLE) && start;
  assign shifting = (state_q == RUN);
  assign last_bit = shifting && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registered below so flags align with the state they describe.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d != IDLE) busy_d = 1'b1;
    if (state_d == DONE) done_d = 1'b1;
  end

  // Datapath next-state: capture on accept, shift on every RUN cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (shifting) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
      sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
      carry_d = fa_carry;
      cout_d  = fa_carry;
      if (!last_bit) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the MSB (carry_q) differs from carry out.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) ovf_d = carry_q ^ fa_carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
